// File: rtl/pipes.sv
// Shared pipeline types: memory size encoding and data-memory responder request/response types.
package pipes;

  localparam int unsigned DMEM_LAT_W = 4;

  typedef enum logic [2:0] {
    MEM_B = 3'd0,
    MEM_H = 3'd1,
    MEM_W = 3'd2,
    MEM_D = 3'd3
  } MemSizeType;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    MemSizeType  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dmem_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
    logic        error;
  } dmem_resp_t;

  // Byte accesses never misalign; unknown size codes are treated as aligned.
  function automatic logic dmem_misaligned(MemSizeType size, logic [2:0] lo);
    logic mis;
    mis = 1'b0;
    case (size)
      MEM_H:   mis = lo[0] != 1'b0;
      MEM_W:   mis = lo[1:0] != 2'b00;
      MEM_D:   mis = lo != 3'b000;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port byte-writable RAM, 64-bit words: synchronous write, combinational read.
module dmem_array #(
  parameter int unsigned Depth = 1024
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [7:0]               be_i,
  input  logic [$clog2(Depth)-1:0] idx_i,
  input  logic [63:0]              wdata_i,
  output logic [63:0]              rdata_o
);

  logic [63:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 8; i++) begin
        if (be_i[i]) mem_q[idx_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the core's load/store bus.
// Optional misalignment check enabled by defining DMEM_MISALIGN_CHECK_EN.
module dmem_responder
  import pipes::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  output logic        resp_error
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam logic [DMEM_LAT_W-1:0] LatInit = DMEM_LAT_W'(LATENCY - 1);

  dmem_state_t           state_q, state_d;
  logic [DMEM_LAT_W-1:0] cnt_q, cnt_d;
  dmem_req_t             req_in, req_q;
  logic [63:0]           data_q;
  logic [63:0]           rdata;
  logic                  capture;
  logic                  err;
  logic                  mem_we;
  dmem_resp_t            resp;
  logic                  unused_req;

  assign req_in = '{valid: req_valid, addr: req_addr, size: MemSizeType'(req_size),
                    strobe: req_strobe, data: req_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      req_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (capture) req_q <= req_in;
      if (state_q == RESP) data_q <= resp.data;
    end
  end

  // Counter reaches 0 on the transition into RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          capture = 1'b1;
          cnt_d   = LatInit;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - DMEM_LAT_W'(1);
        if (cnt_q <= DMEM_LAT_W'(1)) state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef DMEM_MISALIGN_CHECK_EN
  assign err        = dmem_misaligned(req_q.size, req_q.addr[2:0]);
  assign unused_req = ^{req_q.valid, req_q.addr[63:IdxW+3]};
`else
  assign err        = 1'b0;
  assign unused_req = ^{req_q.valid, req_q.addr[63:IdxW+3], req_q.addr[2:0], req_q.size};
`endif

  assign mem_we = (state_q == RESP) && (req_q.strobe != 8'h00) && !err;

  dmem_array #(
    .Depth(DEPTH_WORDS)
  ) u_array (
    .clk_i  (clk),
    .we_i   (mem_we),
    .be_i   (req_q.strobe),
    .idx_i  (req_q.addr[3 +: IdxW]),
    .wdata_i(req_q.data),
    .rdata_o(rdata)
  );

  // Read data is the pre-write word; outside RESP the last response is held.
  always_comb begin
    resp = '0;
    resp.data = data_q;
    if (state_q == RESP) begin
      resp.addr_ok = 1'b1;
      resp.data_ok = 1'b1;
      resp.error   = err;
      resp.data    = err ? 64'h0 : rdata;
    end
  end

  assign resp_addr_ok = resp.addr_ok;
  assign resp_data_ok = resp.data_ok;
  assign resp_data    = resp.data;
  assign resp_error   = resp.error;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder; honours DMEM_MISALIGN_CHECK_EN like the RTL.
module tb_dmem_responder;

  localparam int LAT = 2;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [63:0] resp_data;
  logic        resp_error;

  typedef struct {
    bit          known;
    logic [63:0] data;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model[int];
  int          total = 0;
  int          bad = 0;

  dmem_responder #(
    .DEPTH_WORDS(1024),
    .LATENCY    (LAT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_size    (req_size),
    .req_strobe  (req_strobe),
    .req_data    (req_data),
    .resp_addr_ok(resp_addr_ok),
    .resp_data_ok(resp_data_ok),
    .resp_data   (resp_data),
    .resp_error  (resp_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit tb_misaligned(logic [2:0] sz, logic [63:0] a);
    case (sz)
      3'd1:    return a[0] != 1'b0;
      3'd2:    return a[1:0] != 2'b00;
      3'd3:    return a[2:0] != 3'b000;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one request from a negedge, push its expectation, and check the response.
  task automatic run_req(input string name, input logic [63:0] a, input logic [2:0] sz,
                         input logic [7:0] st, input logic [63:0] d, input int exp_lat,
                         input bit hold, output logic [63:0] got);
    exp_t        e;
    int          idx;
    int          lat;
    bit          seen;
    logic [63:0] w;
    idx        = int'(a[12:3]);
    req_valid  = 1'b1;
    req_addr   = a;
    req_size   = sz;
    req_strobe = st;
    req_data   = d;
    e.err   = CHECK_EN && tb_misaligned(sz, a);
    e.known = e.err || model.exists(idx);
    e.data  = e.err ? 64'h0 : (model.exists(idx) ? model[idx] : 64'h0);
    sb.push_back(e);
    if (!e.err && st != 8'h00) begin
      w = model.exists(idx) ? model[idx] : 64'h0;
      for (int i = 0; i < 8; i++) if (st[i]) w[8*i +: 8] = d[8*i +: 8];
      model[idx] = w;
    end
    lat  = 0;
    seen = 1'b0;
    got  = 64'h0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (resp_data_ok === 1'b1) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s timeout: no resp_data_ok within 20 cycles", name);
      void'(sb.pop_front());
      req_valid = 1'b0;
      return;
    end
    e = sb.pop_front();
    got = resp_data;
    if (lat !== exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d cycles, want %0d", name, lat, exp_lat);
    end
    total++;
    if (resp_addr_ok !== 1'b1) begin
      bad++;
      $display("FAIL %s addr_ok: got %b, want 1 with data_ok", name, resp_addr_ok);
    end
    total++;
    if (resp_error !== e.err) begin
      bad++;
      $display("FAIL %s error: got %b, want %b", name, resp_error, e.err);
    end
    if (e.known) begin
      total++;
      if (resp_data !== e.data) begin
        bad++;
        $display("FAIL %s data: got %h, want %h", name, resp_data, e.data);
      end
    end
    if (!hold) begin
      req_valid = 1'b0;
      @(negedge clk);
      total++;
      if (resp_data_ok !== 1'b0 || resp_addr_ok !== 1'b0) begin
        bad++;
        $display("FAIL %s pulse: data_ok=%b addr_ok=%b after response, want 0 0", name,
                 resp_data_ok, resp_addr_ok);
      end
    end
  endtask

  task automatic test_reset;
    logic [63:0] got;
    reset_n   = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (resp_addr_ok !== 1'b0 || resp_data_ok !== 1'b0 || resp_error !== 1'b0) begin
      bad++;
      $display("FAIL reset flags: addr_ok=%b data_ok=%b error=%b, want 0 0 0", resp_addr_ok,
               resp_data_ok, resp_error);
    end
    total++;
    if (resp_data !== 64'h0) begin
      bad++;
      $display("FAIL reset data: got %h, want 0", resp_data);
    end
    reset_n = 1'b1;
    @(negedge clk);
    run_req("rd_0x10", 64'h10, 3'd3, 8'h00, 64'h0, LAT, 1'b0, got);
  endtask

  task automatic test_strobe;
    logic [63:0] got;
    run_req("wr_full_0x20", 64'h20, 3'd3, 8'hFF, 64'h1122334455667788, LAT, 1'b0, got);
    run_req("wr_byte_0x20", 64'h20, 3'd0, 8'h01, 64'h00000000000000AA, LAT, 1'b0, got);
    run_req("rd_0x20", 64'h20, 3'd3, 8'h00, 64'h0, LAT, 1'b0, got);
    total++;
    if (got !== 64'h11223344556677AA) begin
      bad++;
      $display("FAIL strobe_merge: got %h, want 11223344556677aa", got);
    end
    @(negedge clk);
    total++;
    if (resp_data !== 64'h11223344556677AA) begin
      bad++;
      $display("FAIL data_hold: got %h, want 11223344556677aa", resp_data);
    end
  endtask

  task automatic test_wrap;
    logic [63:0] got;
    run_req("wr_0x2000", 64'h2000, 3'd3, 8'hFF, 64'hDEAD, LAT, 1'b0, got);
    run_req("rd_0x0", 64'h0, 3'd3, 8'h00, 64'h0, LAT, 1'b0, got);
    total++;
    if (got !== 64'hDEAD) begin
      bad++;
      $display("FAIL wrap: got %h, want dead", got);
    end
  endtask

  task automatic test_reset_mid;
    logic [63:0] got;
    int          stray;
    run_req("wr_0x40", 64'h40, 3'd3, 8'hFF, 64'hCAFEF00D12345678, LAT, 1'b0, got);
    req_valid  = 1'b1;
    req_addr   = 64'h40;
    req_size   = 3'd3;
    req_strobe = 8'hFF;
    req_data   = 64'hFFFFFFFFFFFFFFFF;
    @(negedge clk);
    reset_n   = 1'b0;
    req_valid = 1'b0;
    #1;
    total++;
    if (resp_data_ok !== 1'b0 || resp_data !== 64'h0) begin
      bad++;
      $display("FAIL reset_mid outputs: data_ok=%b data=%h, want 0 0", resp_data_ok, resp_data);
    end
    @(negedge clk);
    reset_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (resp_data_ok !== 1'b0) stray++;
    end
    total++;
    if (stray != 0) begin
      bad++;
      $display("FAIL reset_mid stray: got %0d data_ok pulses, want 0", stray);
    end
    run_req("rd_0x40", 64'h40, 3'd3, 8'h00, 64'h0, LAT, 1'b0, got);
    total++;
    if (got !== 64'hCAFEF00D12345678) begin
      bad++;
      $display("FAIL reset_mid no_write: got %h, want cafef00d12345678", got);
    end
  endtask

  task automatic test_misalign;
    logic [63:0] got;
    logic [63:0] want;
    run_req("wr_0x40_full", 64'h40, 3'd3, 8'hFF, 64'h0123456789ABCDEF, LAT, 1'b0, got);
    run_req("wr_0x42_mis", 64'h42, 3'd2, 8'h3C, 64'h0000A1B2C3D40000, LAT, 1'b0, got);
    run_req("rd_0x40_mis", 64'h40, 3'd3, 8'h00, 64'h0, LAT, 1'b0, got);
    want = CHECK_EN ? 64'h0123456789ABCDEF : 64'h0123A1B2C3D4CDEF;
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL misalign mem: got %h, want %h", got, want);
    end
    run_req("rd_0x41_byte", 64'h41, 3'd0, 8'h00, 64'h0, LAT, 1'b0, got);
  endtask

  task automatic test_back_to_back;
    logic [63:0] got;
    run_req("b2b_wr_0x80", 64'h80, 3'd3, 8'hFF, 64'h5555AAAA33334444, LAT, 1'b1, got);
    run_req("b2b_rd_0x80", 64'h80, 3'd3, 8'h00, 64'h0, LAT + 1, 1'b1, got);
    total++;
    if (got !== 64'h5555AAAA33334444) begin
      bad++;
      $display("FAIL b2b read_after_write: got %h, want 5555aaaa33334444", got);
    end
    run_req("b2b_wr_0x88", 64'h88, 3'd1, 8'h0C, 64'h00000000BEEF0000, LAT + 1, 1'b1, got);
    run_req("b2b_rd_0x88", 64'h88, 3'd3, 8'h00, 64'h0, LAT + 1, 1'b0, got);
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 64'h0;
    req_size   = 3'd0;
    req_strobe = 8'h00;
    req_data   = 64'h0;
    test_reset();
    test_strobe();
    test_wrap();
    test_reset_mid();
    test_misalign();
    model[int'(13'h88 >> 3)] = model[int'(13'h88 >> 3)];
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
